// File: rtl/counter_pkg.sv
// Shared types and default widths for the up/down counter family.
package counter_pkg;

  localparam int OUT_W_DEF      = 10;
  localparam int PRESCALE_W_DEF = 23;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_BOUNCE  = 2'd2,
    CNT_ONESHOT = 2'd3
  } cnt_mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: tick_o fires on every (div_i+1)-th enabled cycle.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] psc_q;
  logic [PRESCALE_W-1:0] psc_d;

  always_comb begin
    psc_d = psc_q;
    if (clr_i) begin
      psc_d = '0;
    end else if (en_i) begin
      psc_d = (psc_q == div_i) ? '0 : psc_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

  assign tick_o = en_i & (psc_q == div_i);

endmodule

// File: rtl/updown_counter_gen.sv
// Up/down counter with prescaler, preload and wrap/saturate/bounce/one-shot
// boundary handling; tc_o is a registered pulse for chaining.
module updown_counter_gen
  import counter_pkg::*;
#(
  parameter int OUT_W      = OUT_W_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int MAX_VAL    = 2**OUT_W - 1,
  parameter int MIN_VAL    = 0
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic                  preload_n,
  input  logic [OUT_W-1:0]      load_val_i,
  input  logic                  dir_i,
  input  cnt_mode_e             mode_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic [OUT_W-1:0]      count_o,
  output logic                  tc_o,
  output logic                  done_o
);

  localparam logic [OUT_W-1:0] MAX_C = OUT_W'(MAX_VAL);
  localparam logic [OUT_W-1:0] MIN_C = OUT_W'(MIN_VAL);

  logic [OUT_W-1:0] count_q, count_d;
  logic             bdir_q, bdir_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             init_q;
  logic             tick;

  logic             bdir_eff;
  logic             step_up;
  logic             at_edge;
  logic [OUT_W-1:0] boundary;
  logic [OUT_W-1:0] count_step;
  logic [OUT_W-1:0] load_clamped;
  int               load_int;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_psc (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .en_i     (en_i),
    .clr_i    (~preload_n),
    .div_i    (div_i),
    .tick_o   (tick)
  );

  // Widened to int so the clamp compares stay meaningful for any MIN/MAX.
  assign load_int     = int'(load_val_i);
  assign load_clamped = (load_int < MIN_VAL) ? MIN_C :
                        (load_int > MAX_VAL) ? MAX_C : load_val_i;

  // Until the first edge after reset, bounce direction follows dir_i.
  assign bdir_eff   = init_q ? dir_i : bdir_q;
  assign step_up    = (mode_i == CNT_BOUNCE) ? bdir_eff : dir_i;
  assign boundary   = step_up ? MAX_C : MIN_C;
  assign at_edge    = (count_q == boundary);
  assign count_step = step_up ? count_q + OUT_W'(1) : count_q - OUT_W'(1);

  always_comb begin
    count_d = count_q;
    bdir_d  = bdir_eff;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (!preload_n) begin
      count_d = load_clamped;
      bdir_d  = dir_i;
      done_d  = 1'b0;
    end else if (tick) begin
      case (mode_i)
        CNT_WRAP: begin
          if (at_edge) begin
            count_d = step_up ? MIN_C : MAX_C;
            tc_d    = 1'b1;
          end else begin
            count_d = count_step;
          end
        end
        CNT_SAT: begin
          if (at_edge) tc_d = 1'b1;
          else         count_d = count_step;
        end
        CNT_BOUNCE: begin
          if (at_edge) begin
            count_d = step_up ? MAX_C - OUT_W'(1) : MIN_C + OUT_W'(1);
            bdir_d  = ~step_up;
          end else begin
            count_d = count_step;
            if (count_step == boundary) begin
              bdir_d = ~step_up;
              tc_d   = 1'b1;
            end
          end
        end
        CNT_ONESHOT: begin
          if (!done_q) begin
            if (!at_edge) count_d = count_step;
            if (at_edge || count_step == boundary) begin
              done_d = 1'b1;
              tc_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= MIN_C;
      bdir_q  <= 1'b1;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
      init_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      bdir_q  <= bdir_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
      init_q  <= 1'b0;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;

endmodule
